stage_ex: RTL and testbench

Execute stage of the 16-bit pipelined processor, placed directly downstream of the ID/EX pipeline register. It consumes the registered opcode, the two register-file operands and the sign-extended immediate, then computes the ALU result and branch decision. Results are registered into the EX/MEM boundary. It also runs an optional iterative 16-cycle multiplier that stalls the front of the pipeline while busy.

---
 rtl/stage_ex_pkg.sv | 29 ++
 rtl/stage_ex_if.sv | 34 +++
 rtl/stage_ex_multiplier.sv | 56 +++++
 rtl/stage_ex.sv | 135 +++++++++++++
 tb/tb_stage_ex.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_ex_pkg.sv
// Shared pipeline definitions: datapath widths, opcode map and EX-stage FSM states.
package pipeline_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_ADDI = 4'd9;
   localparam logic [3:0] OP_LW   = 4'd10;
   localparam logic [3:0] OP_SW   = 4'd11;
   localparam logic [3:0] OP_BEQ  = 4'd12;
   localparam logic [3:0] OP_BNE  = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_LUI  = 4'd15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_t;

endpackage

// File: rtl/stage_ex_if.sv
// ID/EX -> EX/MEM signal bundle; master is the pipeline side, slave is stage_ex.
interface stage_ex_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);

   logic              valid_in;
   logic [3:0]        opcode_in;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [DATA_W-1:0] imm_in;
   logic [REG_AW-1:0] rd_in;
   logic              flush;
   logic              stall_out;
   logic              valid_out;
   logic [DATA_W-1:0] result_out;
   logic [DATA_W-1:0] store_data_out;
   logic [REG_AW-1:0] rd_out;
   logic [3:0]        opcode_out;
   logic              branch_taken_out;

   modport master (
      output valid_in, opcode_in, operand_a, operand_b, imm_in, rd_in, flush,
      input  stall_out, valid_out, result_out, store_data_out, rd_out,
             opcode_out, branch_taken_out
   );

   modport slave (
      input  valid_in, opcode_in, operand_a, operand_b, imm_in, rd_in, flush,
      output stall_out, valid_out, result_out, store_data_out, rd_out,
             opcode_out, branch_taken_out
   );

endinterface

// File: rtl/stage_ex_multiplier.sv
// Iterative 16-step shift-add multiplier (low 16 bits of product); built only with STAGE_EX_MUL_EN.
`ifdef STAGE_EX_MUL_EN
module ex_multiplier
   import pipeline_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_kill,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_product
);

   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;
   logic [3:0]        r_count;
   logic              r_busy;
   logic [DATA_W-1:0] w_acc_next;

   // Product is presented combinationally so the final step lands in EX/MEM on the same edge.
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign o_product  = w_acc_next;
   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_count == 4'd15);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else if (i_kill) begin
         r_busy  <= 1'b0;
         r_count <= '0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_count  <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + 4'd1;
         if (r_count == 4'd15) r_busy <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/stage_ex.sv
// Execute stage: combinational ALU + EX/MEM registers; STAGE_EX_MUL_EN adds the stalling multiplier.
module stage_ex #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input logic       clock,
   input logic       reset,
   stage_ex_if.slave bus
);

   import pipeline_pkg::*;

   logic [DATA_W-1:0] w_alu;
   logic              w_branch;
   logic              r_valid;
   logic              r_branch;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_store;
   logic [REG_AW-1:0] r_rd;
   logic [3:0]        r_opcode;

   // OP_MUL falls to the default: the single-cycle result for MUL is zero.
   always_comb begin
      w_alu    = '0;
      w_branch = 1'b0;
      case (bus.opcode_in)
         OP_ADD:                w_alu = bus.operand_a + bus.operand_b;
         OP_SUB:                w_alu = bus.operand_a - bus.operand_b;
         OP_AND:                w_alu = bus.operand_a & bus.operand_b;
         OP_OR:                 w_alu = bus.operand_a | bus.operand_b;
         OP_XOR:                w_alu = bus.operand_a ^ bus.operand_b;
         OP_SLT:                w_alu = {{(DATA_W-1){1'b0}},
                                         ($signed(bus.operand_a) < $signed(bus.operand_b))};
         OP_SLL:                w_alu = bus.operand_a << bus.operand_b[3:0];
         OP_SRL:                w_alu = bus.operand_a >> bus.operand_b[3:0];
         OP_ADDI, OP_LW, OP_SW: w_alu = bus.operand_a + bus.imm_in;
         OP_BEQ: begin
            w_alu    = bus.operand_a + bus.imm_in;
            w_branch = (bus.operand_a == bus.operand_b);
         end
         OP_BNE: begin
            w_alu    = bus.operand_a + bus.imm_in;
            w_branch = (bus.operand_a != bus.operand_b);
         end
         OP_LUI:                w_alu = {bus.imm_in[7:0], 8'h00};
         default:               w_alu = '0;
      endcase
   end

`ifdef STAGE_EX_MUL_EN
   ex_state_t         r_state;
   logic [REG_AW-1:0] r_mul_rd;
   logic              w_mul_start;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_mul_product;

   assign w_mul_start = (r_state == ST_IDLE) && bus.valid_in && !bus.flush &&
                        (bus.opcode_in == OP_MUL);

   ex_multiplier u_mul (
      .clock     (clock),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_kill    (bus.flush),
      .i_a       (bus.operand_a),
      .i_b       (bus.operand_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   assign bus.stall_out = (r_state == ST_MUL);
`else
   assign bus.stall_out = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
`ifdef STAGE_EX_MUL_EN
         r_state  <= ST_IDLE;
         r_mul_rd <= '0;
`endif
         r_valid  <= 1'b0;
         r_branch <= 1'b0;
         r_result <= '0;
         r_store  <= '0;
         r_rd     <= '0;
         r_opcode <= OP_NOP;
      end else if (bus.flush) begin
`ifdef STAGE_EX_MUL_EN
         r_state  <= ST_IDLE;
`endif
         r_valid  <= 1'b0;
         r_branch <= 1'b0;
      end else begin
`ifdef STAGE_EX_MUL_EN
         // The MUL branches chain into the single-cycle path through the trailing else.
         if (r_state == ST_MUL) begin
            r_valid <= 1'b0;
            if (w_mul_busy && w_mul_done) begin
               r_state  <= ST_IDLE;
               r_valid  <= 1'b1;
               r_result <= w_mul_product;
               r_rd     <= r_mul_rd;
               r_opcode <= OP_MUL;
               r_branch <= 1'b0;
            end
         end else if (bus.valid_in && (bus.opcode_in == OP_MUL)) begin
            r_state  <= ST_MUL;
            r_mul_rd <= bus.rd_in;
            r_valid  <= 1'b0;
         end else
`endif
         if (bus.valid_in) begin
            r_valid  <= 1'b1;
            r_result <= w_alu;
            r_store  <= bus.operand_b;
            r_rd     <= bus.rd_in;
            r_opcode <= bus.opcode_in;
            r_branch <= w_branch;
         end else begin
            r_valid  <= 1'b0;
         end
      end
   end

   assign bus.valid_out        = r_valid;
   assign bus.branch_taken_out = r_branch;
   assign bus.result_out       = r_result;
   assign bus.store_data_out   = r_store;
   assign bus.rd_out           = r_rd;
   assign bus.opcode_out       = r_opcode;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: vector table for single-cycle ops plus MUL/flush/reset sequences.
module tb_stage_ex;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   stage_ex_if #(.DATA_W(16), .REG_AW(3)) bus ();

   stage_ex #(.DATA_W(16), .REG_AW(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [2:0]  rd;
      logic        exp_valid;
      logic [15:0] exp_result;
      logic        exp_branch;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] imm, input logic [2:0] rd);
      bus.valid_in  = v;
      bus.opcode_in = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.imm_in    = imm;
      bus.rd_in     = rd;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},  {31'd0, bus.valid_out}, 32'd0);
      chk({tag, "_branch"}, {31'd0, bus.branch_taken_out}, 32'd0);
      chk({tag, "_stall"},  {31'd0, bus.stall_out}, 32'd0);
      chk({tag, "_result"}, {16'd0, bus.result_out}, 32'd0);
      chk({tag, "_store"},  {16'd0, bus.store_data_out}, 32'd0);
      chk({tag, "_rd"},     {29'd0, bus.rd_out}, 32'd0);
      chk({tag, "_opcode"}, {28'd0, bus.opcode_out}, 32'd0);
   endtask

   logic [15:0] exp_store;
   logic [2:0]  exp_rd;
   logic [3:0]  exp_op;
   int          n_stall;
   int          bad_valid;
   int          seen;
   bit          done;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.flush = 1'b0;
      drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0);

      vecs[0]  = '{1'b1, 4'd1,  16'h7FFF, 16'h0001, 16'h0000, 3'd1, 1'b1, 16'h8000, 1'b0};
      vecs[1]  = '{1'b1, 4'd2,  16'h0000, 16'h0001, 16'h0000, 3'd2, 1'b1, 16'hFFFF, 1'b0};
      vecs[2]  = '{1'b1, 4'd3,  16'hF0F0, 16'h3C3C, 16'h0000, 3'd3, 1'b1, 16'h3030, 1'b0};
      vecs[3]  = '{1'b1, 4'd4,  16'hF0F0, 16'h0F01, 16'h0000, 3'd4, 1'b1, 16'hFFF1, 1'b0};
      vecs[4]  = '{1'b1, 4'd5,  16'hAAAA, 16'hFFFF, 16'h0000, 3'd5, 1'b1, 16'h5555, 1'b0};
      vecs[5]  = '{1'b1, 4'd6,  16'hFFFE, 16'h0001, 16'h0000, 3'd6, 1'b1, 16'h0001, 1'b0};
      vecs[6]  = '{1'b1, 4'd6,  16'h0001, 16'hFFFE, 16'h0000, 3'd7, 1'b1, 16'h0000, 1'b0};
      vecs[7]  = '{1'b1, 4'd7,  16'h0001, 16'h0013, 16'h0000, 3'd1, 1'b1, 16'h0008, 1'b0};
      vecs[8]  = '{1'b1, 4'd8,  16'h8000, 16'h0004, 16'h0000, 3'd2, 1'b1, 16'h0800, 1'b0};
      vecs[9]  = '{1'b1, 4'd9,  16'h0010, 16'h1234, 16'hFFFF, 3'd3, 1'b1, 16'h000F, 1'b0};
      vecs[10] = '{1'b1, 4'd10, 16'h1000, 16'h0000, 16'h0004, 3'd4, 1'b1, 16'h1004, 1'b0};
      vecs[11] = '{1'b1, 4'd11, 16'h2000, 16'hBEEF, 16'hFFF0, 3'd0, 1'b1, 16'h1FF0, 1'b0};
      vecs[12] = '{1'b1, 4'd12, 16'h0042, 16'h0042, 16'h0010, 3'd0, 1'b1, 16'h0052, 1'b1};
      vecs[13] = '{1'b1, 4'd13, 16'h0042, 16'h0042, 16'h0010, 3'd0, 1'b1, 16'h0052, 1'b0};
      vecs[14] = '{1'b1, 4'd13, 16'h0042, 16'h0043, 16'h0010, 3'd0, 1'b1, 16'h0052, 1'b1};
      vecs[15] = '{1'b1, 4'd15, 16'h5555, 16'h0007, 16'h12AB, 3'd5, 1'b1, 16'hAB00, 1'b0};
      vecs[16] = '{1'b0, 4'd1,  16'h1111, 16'h2222, 16'h0000, 3'd6, 1'b0, 16'hAB00, 1'b0};
      vecs[17] = '{1'b1, 4'd0,  16'h1234, 16'h5678, 16'h9ABC, 3'd7, 1'b1, 16'h0000, 1'b0};

      // Asynchronous reset must clear outputs before any clock edge
      #2;
      chk_all_zero("reset_initial");
      #10 reset = 1'b0;
      step();

      exp_store = 16'h0000;
      exp_rd    = 3'd0;
      exp_op    = 4'd0;
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].rd);
         step();
         if (vecs[i].valid) begin
            exp_store = vecs[i].b;
            exp_rd    = vecs[i].rd;
            exp_op    = vecs[i].op;
         end
         chk($sformatf("vec%0d_valid", i),  {31'd0, bus.valid_out}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_result", i), {16'd0, bus.result_out}, {16'd0, vecs[i].exp_result});
         chk($sformatf("vec%0d_branch", i), {31'd0, bus.branch_taken_out}, {31'd0, vecs[i].exp_branch});
         chk($sformatf("vec%0d_store", i),  {16'd0, bus.store_data_out}, {16'd0, exp_store});
         chk($sformatf("vec%0d_rd", i),     {29'd0, bus.rd_out}, {29'd0, exp_rd});
         chk($sformatf("vec%0d_opcode", i), {28'd0, bus.opcode_out}, {28'd0, exp_op});
         chk($sformatf("vec%0d_stall", i),  {31'd0, bus.stall_out}, 32'd0);
      end

      // Flush wins over a valid taken branch in the same cycle
      drive(1'b1, 4'd12, 16'h0042, 16'h0042, 16'h0010, 3'd1);
      step();
      chk("flushpri_pre_branch", {31'd0, bus.branch_taken_out}, 32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flushpri_valid",  {31'd0, bus.valid_out}, 32'd0);
      chk("flushpri_branch", {31'd0, bus.branch_taken_out}, 32'd0);

`ifdef STAGE_EX_MUL_EN
      // MUL followed by ADD held stable upstream during the stall
      drive(1'b1, 4'd14, 16'h0123, 16'h0010, 16'h0000, 3'd5);
      step();
      chk("mul_accept_stall",  {31'd0, bus.stall_out}, 32'd1);
      chk("mul_accept_bubble", {31'd0, bus.valid_out}, 32'd0);
      drive(1'b1, 4'd1, 16'h0001, 16'h0002, 16'h0000, 3'd6);
      n_stall   = 1;
      bad_valid = 0;
      done      = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         step();
         if (bus.stall_out) begin
            n_stall++;
            if (bus.valid_out) bad_valid++;
         end else begin
            done = 1'b1;
         end
      end
      chk("mul_stall_len",   n_stall, 32'd16);
      chk("mul_valid_stall", bad_valid, 32'd0);
      chk("mul_valid",  {31'd0, bus.valid_out}, 32'd1);
      chk("mul_result", {16'd0, bus.result_out}, 32'h1230);
      chk("mul_rd",     {29'd0, bus.rd_out}, 32'd5);
      chk("mul_opcode", {28'd0, bus.opcode_out}, 32'd14);
      chk("mul_branch", {31'd0, bus.branch_taken_out}, 32'd0);
      step();
      chk("mul_next_valid",  {31'd0, bus.valid_out}, 32'd1);
      chk("mul_next_result", {16'd0, bus.result_out}, 32'h0003);
      chk("mul_next_rd",     {29'd0, bus.rd_out}, 32'd6);
      chk("mul_next_stall",  {31'd0, bus.stall_out}, 32'd0);

      // Flush at step 8 abandons the product
      drive(1'b1, 4'd14, 16'h0123, 16'h0010, 16'h0000, 3'd5);
      step();
      drive(1'b1, 4'd1, 16'h0100, 16'h0001, 16'h0000, 3'd2);
      for (int k = 0; k < 8; k++) step();
      chk("flush8_pre_stall", {31'd0, bus.stall_out}, 32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush8_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("flush8_stall", {31'd0, bus.stall_out}, 32'd0);
      step();
      chk("flush8_add_valid",  {31'd0, bus.valid_out}, 32'd1);
      chk("flush8_add_result", {16'd0, bus.result_out}, 32'h0101);
      chk("flush8_add_opcode", {28'd0, bus.opcode_out}, 32'd1);
      drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.valid_out || bus.stall_out) seen++;
      end
      chk("flush8_no_late_product", seen, 32'd0);

      // Flush in the same cycle as the final step
      drive(1'b1, 4'd14, 16'h0003, 16'h0005, 16'h0000, 3'd7);
      step();
      drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
      for (int k = 0; k < 15; k++) step();
      chk("flushlast_pre_stall", {31'd0, bus.stall_out}, 32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flushlast_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("flushlast_stall", {31'd0, bus.stall_out}, 32'd0);
      step();
      chk("flushlast_after_valid", {31'd0, bus.valid_out}, 32'd0);
`else
      drive(1'b1, 4'd14, 16'h0123, 16'h0010, 16'h0000, 3'd5);
      step();
      chk("mul_off_valid",  {31'd0, bus.valid_out}, 32'd1);
      chk("mul_off_result", {16'd0, bus.result_out}, 32'h0000);
      chk("mul_off_opcode", {28'd0, bus.opcode_out}, 32'd14);
      chk("mul_off_rd",     {29'd0, bus.rd_out}, 32'd5);
      chk("mul_off_stall",  {31'd0, bus.stall_out}, 32'd0);
`endif

      // Mid-cycle reset (during a multiply when present), then recovery
      drive(1'b1, 4'd1, 16'h1111, 16'h2222, 16'h0000, 3'd3);
      step();
      chk("prereset_result", {16'd0, bus.result_out}, 32'h3333);
`ifdef STAGE_EX_MUL_EN
      drive(1'b1, 4'd14, 16'h0123, 16'h0010, 16'h0000, 3'd5);
      step();
      drive(1'b1, 4'd1, 16'h0005, 16'h0006, 16'h0000, 3'd4);
      for (int k = 0; k < 8; k++) step();
      chk("reset8_pre_stall", {31'd0, bus.stall_out}, 32'd1);
`else
      drive(1'b1, 4'd1, 16'h0005, 16'h0006, 16'h0000, 3'd4);
`endif
      #2 reset = 1'b1;
      #1;
      chk_all_zero("reset_mid");
      #3 reset = 1'b0;
      step();
      chk("reset_add_valid",  {31'd0, bus.valid_out}, 32'd1);
      chk("reset_add_result", {16'd0, bus.result_out}, 32'h000B);
      chk("reset_add_rd",     {29'd0, bus.rd_out}, 32'd4);
      chk("reset_add_stall",  {31'd0, bus.stall_out}, 32'd0);
      drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
      seen = 0;
      for (int k = 0; k < 18; k++) begin
         step();
         if (bus.valid_out) seen++;
      end
      chk("reset_no_late_product", seen, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
